// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single Cache port between two requesters, A and B. Every
//   transaction is sequenced as issue -> settle -> wait. Ties are resolved
//   round-robin. A watchdog aborts a wait that stalls and sets a sticky error.
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   reqX_valid/address/data_in/write_enable   request from X (write_enable 0 = read)
//   reqX_ready                  1-cycle pulse: request accepted, payload latched
//   reqX_data_out/reqX_done     read data (held) and 1-cycle completion pulse
//   cache_address/data_in/write_enable        to Cache
//   cache_data_out/data_out_ready/busy        from Cache
//   error                       sticky watchdog timeout flag
module cache_arbiter #(
    parameter int          ADDRESS_BITWIDTH = 32,
    parameter int          DATA_BITWIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reqA_valid,
    input  logic [ADDRESS_BITWIDTH-1:0]   reqA_address,
    input  logic [DATA_BITWIDTH-1:0]      reqA_data_in,
    input  logic [DATA_BITWIDTH/8-1:0]    reqA_write_enable,
    output logic                          reqA_ready,
    output logic [DATA_BITWIDTH-1:0]      reqA_data_out,
    output logic                          reqA_done,
    input  logic                          reqB_valid,
    input  logic [ADDRESS_BITWIDTH-1:0]   reqB_address,
    input  logic [DATA_BITWIDTH-1:0]      reqB_data_in,
    input  logic [DATA_BITWIDTH/8-1:0]    reqB_write_enable,
    output logic                          reqB_ready,
    output logic [DATA_BITWIDTH-1:0]      reqB_data_out,
    output logic                          reqB_done,
    output logic [ADDRESS_BITWIDTH-1:0]   cache_address,
    output logic [DATA_BITWIDTH-1:0]      cache_data_in,
    output logic [DATA_BITWIDTH/8-1:0]    cache_write_enable,
    input  logic [DATA_BITWIDTH-1:0]      cache_data_out,
    input  logic                          cache_data_out_ready,
    input  logic                          cache_busy,
    output logic                          error
);

    localparam int WE_BITWIDTH = DATA_BITWIDTH / 8;
    localparam int WD_BITWIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen on the last permitted wait cycle.
    localparam logic [WD_BITWIDTH-1:0] WD_LIMIT =
        WD_BITWIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_SETTLE     = 3'd2;
    localparam logic [2:0] ST_READ_WAIT  = 3'd3;
    localparam logic [2:0] ST_WRITE_WAIT = 3'd4;

    logic [2:0]             state;
    logic                   grant_b;       // current transaction belongs to B
    logic                   last_grant_b;  // B won the most recent grant
    logic [WE_BITWIDTH-1:0] we_latched;
    logic [WD_BITWIDTH-1:0] wd_count;

    logic                        pick_b;
    logic [ADDRESS_BITWIDTH-1:0] sel_address;
    logic [DATA_BITWIDTH-1:0]    sel_data;
    logic [WE_BITWIDTH-1:0]      sel_we;
    logic                        wait_hit;
    logic                        wd_expired;

    always_comb begin
        // On a tie the port that did not win last time is chosen.
        if (reqA_valid && reqB_valid)
            pick_b = ~last_grant_b;
        else
            pick_b = reqB_valid;
        sel_address = pick_b ? reqB_address      : reqA_address;
        sel_data    = pick_b ? reqB_data_in      : reqA_data_in;
        sel_we      = pick_b ? reqB_write_enable : reqA_write_enable;
    end

    assign wait_hit   = (state == ST_READ_WAIT) ? (cache_data_out_ready && !cache_busy)
                                                : !cache_busy;
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_count == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            grant_b            <= 1'b0;
            last_grant_b       <= 1'b1;
            we_latched         <= '0;
            wd_count           <= '0;
            reqA_ready         <= 1'b0;
            reqA_done          <= 1'b0;
            reqA_data_out      <= '0;
            reqB_ready         <= 1'b0;
            reqB_done          <= 1'b0;
            reqB_data_out      <= '0;
            cache_address      <= '0;
            cache_data_in      <= '0;
            cache_write_enable <= '0;
            error              <= 1'b0;
        end else begin
            reqA_ready <= 1'b0;
            reqB_ready <= 1'b0;
            reqA_done  <= 1'b0;
            reqB_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cache_write_enable <= '0;
                    if (reqA_valid || reqB_valid) begin
                        grant_b            <= pick_b;
                        last_grant_b       <= pick_b;
                        cache_address      <= sel_address;
                        cache_data_in      <= sel_data;
                        we_latched         <= sel_we;
                        // Registered outputs reflect the ISSUE state being entered.
                        cache_write_enable <= sel_we;
                        reqA_ready         <= ~pick_b;
                        reqB_ready         <= pick_b;
                        state              <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cache_write_enable <= '0;
                    state              <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    wd_count <= '0;
                    state    <= (we_latched == '0) ? ST_READ_WAIT : ST_WRITE_WAIT;
                end
                ST_READ_WAIT, ST_WRITE_WAIT: begin
                    if (wait_hit || wd_expired) begin
                        if (wd_expired && !wait_hit)
                            error <= 1'b1;
                        if (state == ST_READ_WAIT) begin
                            if (grant_b)
                                reqB_data_out <= wait_hit ? cache_data_out : '0;
                            else
                                reqA_data_out <= wait_hit ? cache_data_out : '0;
                        end
                        reqA_done <= ~grant_b;
                        reqB_done <= grant_b;
                        state     <= ST_IDLE;
                    end else if (wd_count != '1) begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Directed stimulus for cache_arbiter with a behavioural Cache, a
//   transaction-level reference model compared against the DUT every cycle,
//   and hand-computed checks on latency, grant order and data.
module tb_cache_arbiter;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          WEW = DW / 8;
    localparam int unsigned TO  = 16;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [WEW-1:0] we;
    } req_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           reqA_valid, reqB_valid;
    logic [AW-1:0]  reqA_address, reqB_address;
    logic [DW-1:0]  reqA_data_in, reqB_data_in;
    logic [WEW-1:0] reqA_write_enable, reqB_write_enable;
    logic           reqA_ready, reqB_ready, reqA_done, reqB_done;
    logic [DW-1:0]  reqA_data_out, reqB_data_out;
    logic [AW-1:0]  cache_address;
    logic [DW-1:0]  cache_data_in;
    logic [WEW-1:0] cache_write_enable;
    logic [DW-1:0]  cache_data_out = '0;
    logic           cache_data_out_ready = 1'b0;
    logic           cache_busy;
    logic           error;

    cache_arbiter #(
        .ADDRESS_BITWIDTH(AW),
        .DATA_BITWIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .reqA_valid(reqA_valid), .reqA_address(reqA_address), .reqA_data_in(reqA_data_in),
        .reqA_write_enable(reqA_write_enable), .reqA_ready(reqA_ready),
        .reqA_data_out(reqA_data_out), .reqA_done(reqA_done),
        .reqB_valid(reqB_valid), .reqB_address(reqB_address), .reqB_data_in(reqB_data_in),
        .reqB_write_enable(reqB_write_enable), .reqB_ready(reqB_ready),
        .reqB_data_out(reqB_data_out), .reqB_done(reqB_done),
        .cache_address(cache_address), .cache_data_in(cache_data_in),
        .cache_write_enable(cache_write_enable), .cache_data_out(cache_data_out),
        .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy),
        .error(error)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural Cache ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    int wr_busy     = 0;
    bit rd_ready_en = 1'b1;
    int bcnt        = 0;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (cache_write_enable != '0) begin
            w = mem.exists(cache_address) ? mem[cache_address] : '0;
            for (int i = 0; i < WEW; i++)
                if (cache_write_enable[i]) w[8*i +: 8] = cache_data_in[8*i +: 8];
            mem[cache_address] = w;
            bcnt <= wr_busy;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
        cache_data_out       <= mem.exists(cache_address) ? mem[cache_address] : '0;
        cache_data_out_ready <= rd_ready_en;
    end
    assign cache_busy = (bcnt != 0);

    // ---------------- requester drivers ----------------
    req_t qA[$];
    req_t qB[$];

    initial begin
        reqA_valid = 1'b0; reqA_address = '0; reqA_data_in = '0; reqA_write_enable = '0;
        forever begin
            @(negedge clk);
            if (reqA_valid && reqA_ready) qA.delete(0);
            if (qA.size() > 0) begin
                reqA_valid = 1'b1; reqA_address = qA[0].addr;
                reqA_data_in = qA[0].data; reqA_write_enable = qA[0].we;
            end else reqA_valid = 1'b0;
        end
    end

    initial begin
        reqB_valid = 1'b0; reqB_address = '0; reqB_data_in = '0; reqB_write_enable = '0;
        forever begin
            @(negedge clk);
            if (reqB_valid && reqB_ready) qB.delete(0);
            if (qB.size() > 0) begin
                reqB_valid = 1'b1; reqB_address = qB[0].addr;
                reqB_data_in = qB[0].data; reqB_write_enable = qB[0].we;
            end else reqB_valid = 1'b0;
        end
    end

    // ---------------- transaction-level reference model ----------------
    // Tracks one outstanding transaction by its age in cycles since the grant:
    // age 1 = accepted (ready, enables driven), 2 = settle, >=4 = waiting on Cache.
    logic           e_readyA, e_readyB, e_doneA, e_doneB, e_error;
    logic [DW-1:0]  e_dataA, e_dataB, e_din;
    logic [AW-1:0]  e_addr;
    logic [WEW-1:0] e_cwe;
    bit m_active = 1'b0, m_b = 1'b0, m_last_b = 1'b1, m_read = 1'b0;
    int m_age = 0, m_wait = 0;

    always @(posedge clk) begin
        e_readyA = 1'b0; e_readyB = 1'b0; e_doneA = 1'b0; e_doneB = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_last_b = 1'b1;
            e_dataA = '0; e_dataB = '0; e_addr = '0; e_din = '0; e_cwe = '0; e_error = 1'b0;
        end else if (!m_active) begin
            e_cwe = '0;
            if (reqA_valid || reqB_valid) begin
                m_b      = (reqA_valid && reqB_valid) ? !m_last_b : reqB_valid;
                m_last_b = m_b;
                e_addr   = m_b ? reqB_address : reqA_address;
                e_din    = m_b ? reqB_data_in : reqA_data_in;
                e_cwe    = m_b ? reqB_write_enable : reqA_write_enable;
                m_read   = (e_cwe == '0);
                if (m_b) e_readyB = 1'b1; else e_readyA = 1'b1;
                m_active = 1'b1; m_age = 1; m_wait = 0;
            end
        end else begin
            m_age++;
            if (m_age == 2) e_cwe = '0;
            if (m_age >= 4) begin
                m_wait++;
                if (m_read ? (cache_data_out_ready && !cache_busy) : !cache_busy) begin
                    if (m_read) begin
                        if (m_b) e_dataB = cache_data_out; else e_dataA = cache_data_out;
                    end
                    if (m_b) e_doneB = 1'b1; else e_doneA = 1'b1;
                    m_active = 1'b0;
                end else if (m_wait == TO) begin
                    e_error = 1'b1;
                    if (m_read) begin
                        if (m_b) e_dataB = '0; else e_dataA = '0;
                    end
                    if (m_b) e_doneB = 1'b1; else e_doneA = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    bit chk_en = 1'b0;
    int cyc = 0;
    int rdyA_cyc = 0, doneA_cyc = 0, doneB_cyc = 0, busy_fall_cyc = 0;
    int doneA_n = 0, doneB_n = 0, cwe3_n = 0, busy_n = 0;
    bit prev_busy = 1'b0;
    int order[$];
    int done_cycs[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            check("reqA_ready", reqA_ready, e_readyA);
            check("reqA_done", reqA_done, e_doneA);
            check("reqA_data_out", reqA_data_out, e_dataA);
            check("reqB_ready", reqB_ready, e_readyB);
            check("reqB_done", reqB_done, e_doneB);
            check("reqB_data_out", reqB_data_out, e_dataB);
            check("cache_address", cache_address, e_addr);
            check("cache_data_in", cache_data_in, e_din);
            check("cache_write_enable", cache_write_enable, e_cwe);
            check("error", error, e_error);
            if (reqA_ready) begin order.push_back(0); rdyA_cyc = cyc; end
            if (reqB_ready) order.push_back(1);
            if (reqA_done) begin doneA_n++; doneA_cyc = cyc; done_cycs.push_back(cyc); end
            if (reqB_done) begin doneB_n++; doneB_cyc = cyc; done_cycs.push_back(cyc); end
            if (cache_write_enable == 4'b0011) cwe3_n++;
            if (cache_busy) busy_n++;
            if (prev_busy && !cache_busy) busy_fall_cyc = cyc;
            prev_busy = cache_busy;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic push_req(input bit to_b, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [WEW-1:0] we);
        req_t r;
        r.addr = a; r.data = d; r.we = we;
        if (to_b) qB.push_back(r); else qA.push_back(r);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(qA.size() == 0 && qB.size() == 0 && !reqA_valid && !reqB_valid && !m_active)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_bound"}, (n >= budget), 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    int sA, sB, w0;

    initial begin
        mem[32'h40] = 32'h12345678;
        mem[32'h44] = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            mem[32'h80 + 4*i] = 32'hA000_0000 + i;
            mem[32'hC0 + 4*i] = 32'hB000_0000 + i;
        end
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_error", error, 1'b0);
        check("rst_cwe", cache_write_enable, 4'b0000);
        rst = 1'b0;

        // 1: A read hit
        @(posedge clk); #1;
        sB = doneB_n;
        push_req(1'b0, 32'h40, '0, 4'b0000);
        wait_idle("t1", 50);
        check("t1_dataA", reqA_data_out, 32'h12345678);
        check("t1_latency", doneA_cyc - rdyA_cyc, 3);
        check("t1_no_B_done", doneB_n - sB, 0);

        // 3: B write with 10 busy cycles
        wr_busy = 10; cwe3_n = 0; busy_n = 0; sB = doneB_n;
        @(posedge clk); #1;
        push_req(1'b1, 32'h100, 32'hCAFEBABE, 4'b0011);
        wait_idle("t3", 60);
        check("t3_cwe_cycles", cwe3_n, 1);
        check("t3_busy_cycles", busy_n, 10);
        check("t3_done_after_busy", doneB_cyc - busy_fall_cyc, 1);
        check("t3_doneB_count", doneB_n - sB, 1);

        // 2: both requesters held for four reads each
        wr_busy = 0;
        order.delete(); done_cycs.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 32'h80 + 4*i, '0, 4'b0000);
            push_req(1'b1, 32'hC0 + 4*i, '0, 4'b0000);
        end
        wait_idle("t2", 100);
        check("t2_grants", order.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_grant%0d", i), (i < order.size()) ? order[i] : 3, i % 2);
        for (int i = 1; i < 8; i++)
            check($sformatf("t2_spacing%0d", i),
                  (i < done_cycs.size()) ? done_cycs[i] - done_cycs[i-1] : 0, 4);
        check("t2_lastA", reqA_data_out, 32'hA0000003);
        check("t2_lastB", reqB_data_out, 32'hB0000003);

        // 6: A write then B read of the same address
        wr_busy = 2;
        @(posedge clk); #1;
        push_req(1'b0, 32'h200, 32'hA5A5A5A5, 4'b1111);
        wait_idle("t6w", 50);
        @(posedge clk); #1;
        push_req(1'b1, 32'h200, '0, 4'b0000);
        wait_idle("t6r", 50);
        check("t6_readback", reqB_data_out, 32'hA5A5A5A5);

        // 4: watchdog timeout on an A read, then a normal B read
        check("t4_error_before", error, 1'b0);
        rd_ready_en = 1'b0; sA = doneA_n;
        @(posedge clk); #1;
        push_req(1'b0, 32'h40, '0, 4'b0000);
        wait_idle("t4a", 80);
        check("t4_doneA_count", doneA_n - sA, 1);
        check("t4_timeout_latency", doneA_cyc - rdyA_cyc, 18);
        check("t4_dataA_zero", reqA_data_out, 32'h0);
        check("t4_error", error, 1'b1);
        rd_ready_en = 1'b1;
        @(posedge clk); #1;
        push_req(1'b1, 32'h44, '0, 4'b0000);
        wait_idle("t4b", 50);
        check("t4_dataB", reqB_data_out, 32'h0BADF00D);
        check("t4_error_sticky", error, 1'b1);

        // 5: reset during READ_WAIT
        rd_ready_en = 1'b0;
        @(posedge clk); #1;
        push_req(1'b0, 32'h40, '0, 4'b0000);
        w0 = 0;
        while (!reqA_ready && w0 < 20) begin @(negedge clk); w0++; end
        check("t5_ready_bound", (w0 >= 20), 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_readyA", reqA_ready, 1'b0);
        check("t5_doneA", reqA_done, 1'b0);
        check("t5_dataA", reqA_data_out, 32'h0);
        check("t5_readyB", reqB_ready, 1'b0);
        check("t5_doneB", reqB_done, 1'b0);
        check("t5_dataB", reqB_data_out, 32'h0);
        check("t5_addr", cache_address, 32'h0);
        check("t5_din", cache_data_in, 32'h0);
        check("t5_cwe", cache_write_enable, 4'b0000);
        check("t5_error", error, 1'b0);
        sA = doneA_n;
        repeat (25) @(negedge clk);
        check("t5_no_done", doneA_n - sA, 0);
        rd_ready_en = 1'b1;
        order.delete();
        @(posedge clk); #1;
        push_req(1'b0, 32'h84, '0, 4'b0000);
        push_req(1'b1, 32'hC4, '0, 4'b0000);
        wait_idle("t5", 50);
        check("t5_first_grant_A", (order.size() > 0) ? order[0] : 3, 0);
        check("t5_dataA_after", reqA_data_out, 32'hA0000001);
        check("t5_dataB_after", reqB_data_out, 32'hB0000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
